// File: rtl/dsp_fir_pkg.sv
// Shared constants for the time-multiplexed FIR sequencer: slice opmodes and FSM states.
package dsp_fir_pkg;

   localparam int DW = 18;
   localparam int PW = 48;

   // X/Z selects with the ALU in add mode, no pre-adder, carry-in 0
   localparam logic [7:0] OP_FIRST = 8'h01;
   localparam logic [7:0] OP_ACC   = 8'h09;
   localparam logic [7:0] OP_HOLD  = 8'h08;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      OUTPUT
   } state_e;

endpackage

// File: rtl/fir_tap_bank.sv
// Sample delay line and coefficient registers, with a single read port indexed by tap.
module fir_tap_bank
   import dsp_fir_pkg::*;
#(
   parameter int N_TAPS = 4,
   parameter int AW     = $clog2(N_TAPS)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 shift_en_i,
   input  logic signed [DW-1:0] shift_data_i,
   input  logic                 coef_we_i,
   input  logic [AW-1:0]        coef_addr_i,
   input  logic signed [DW-1:0] coef_wdata_i,
   input  logic [AW-1:0]        tap_idx_i,
   output logic signed [DW-1:0] c_o,
   output logic signed [DW-1:0] x_o
);

   logic [N_TAPS-1:0][DW-1:0] x_q;
   logic [N_TAPS-1:0][DW-1:0] c_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         x_q <= '0;
         c_q <= '0;
      end else begin
         if (shift_en_i)
            x_q <= {x_q[N_TAPS-2:0], shift_data_i};
         // addresses past the last tap are dropped when N_TAPS is not a power of two
         if (coef_we_i && (int'(coef_addr_i) < N_TAPS))
            c_q[coef_addr_i] <= coef_wdata_i;
      end
   end

   assign c_o = c_q[tap_idx_i];
   assign x_o = x_q[tap_idx_i];

endmodule

// File: rtl/dsp_fir_sequencer.sv
// FIR controller feeding a pipelined DSP slice one tap per cycle and capturing the
// accumulated P once the slice pipeline has drained.
module dsp_fir_sequencer
   import dsp_fir_pkg::*;
#(
   parameter int N_TAPS  = 4,
   parameter int DSP_LAT = 3,
   parameter int OP_SKEW = 1,
   parameter int AW      = $clog2(N_TAPS)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_data,
   input  logic                 coef_we,
   input  logic [AW-1:0]        coef_addr,
   input  logic signed [DW-1:0] coef_wdata,
   output logic signed [DW-1:0] dsp_a,
   output logic signed [DW-1:0] dsp_b,
   output logic [7:0]           dsp_opmode,
   input  logic [PW-1:0]        dsp_p,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PW-1:0]        out_data,
   output logic                 busy
);

   localparam int CW = $clog2((N_TAPS > DSP_LAT) ? N_TAPS : DSP_LAT);

   state_e                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [OP_SKEW-1:0][7:0]  op_pipe_q;
   logic [7:0]               op_d;
   logic [PW-1:0]            out_q, out_d;
   logic signed [DW-1:0]     c_k, x_k;
   logic                     idle;

   assign idle = (state_q == IDLE);

   fir_tap_bank #(
      .N_TAPS (N_TAPS),
      .AW     (AW)
   ) u_bank (
      .clk          (clk),
      .rstn         (rstn),
      .shift_en_i   (idle && in_valid),
      .shift_data_i (in_data),
      .coef_we_i    (idle && coef_we),
      .coef_addr_i  (coef_addr),
      .coef_wdata_i (coef_wdata),
      .tap_idx_i    (cnt_q[AW-1:0]),
      .c_o          (c_k),
      .x_o          (x_k)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = OP_HOLD;
      out_d   = out_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = ISSUE;
               cnt_d   = '0;
            end
         end
         ISSUE: begin
            op_d = (cnt_q == '0) ? OP_FIRST : OP_ACC;
            if (cnt_q == CW'(N_TAPS - 1)) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            // last tap's P lands during the final drain cycle
            if (cnt_q == CW'(DSP_LAT - 1)) begin
               out_d   = dsp_p;
               state_d = OUTPUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OUTPUT: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_pipe_q <= '0;
         out_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         out_q        <= out_d;
         op_pipe_q[0] <= op_d;
         for (int i = 1; i < OP_SKEW; i++)
            op_pipe_q[i] <= op_pipe_q[i-1];
      end
   end

   assign dsp_a      = (state_q == ISSUE) ? c_k : '0;
   assign dsp_b      = (state_q == ISSUE) ? x_k : '0;
   assign dsp_opmode = op_pipe_q[OP_SKEW-1];
   assign in_ready   = idle;
   assign busy       = !idle;
   assign out_valid  = (state_q == OUTPUT);
   assign out_data   = out_q;

endmodule

// File: tb/tb_dsp_fir_sequencer.sv
// Bench for dsp_fir_sequencer: a DSP slice model drives dsp_p, a filter model predicts every output.
module tb_dsp_fir_sequencer;

   localparam int N_TAPS  = 4;
   localparam int DSP_LAT = 3;
   localparam int OP_SKEW = 1;
   localparam int AW      = 2;
   localparam int PH_IDLE = 0, PH_RUN = 1, PH_OUT = 2;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [17:0]   in_data = '0;
   logic          coef_we = 1'b0;
   logic [AW-1:0] coef_addr = '0;
   logic [17:0]   coef_wdata = '0;
   logic [17:0]   dsp_a, dsp_b;
   logic [7:0]    dsp_opmode;
   logic [47:0]   dsp_p = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [47:0]   out_data;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   dsp_fir_sequencer #(
      .N_TAPS (N_TAPS), .DSP_LAT (DSP_LAT), .OP_SKEW (OP_SKEW), .AW (AW)
   ) dut (
      .clk (clk), .rstn (rstn),
      .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
      .coef_we (coef_we), .coef_addr (coef_addr), .coef_wdata (coef_wdata),
      .dsp_a (dsp_a), .dsp_b (dsp_b), .dsp_opmode (dsp_opmode), .dsp_p (dsp_p),
      .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // DSP slice: A1/B1 -> M -> P, opmode registered once; not reset, CEs high
   logic [17:0] sa = '0, sb = '0, a1 = '0, b1 = '0;
   logic [7:0]  sop = '0, op_r = '0;
   logic [47:0] m = '0, p = '0;
   initial forever begin
      @(negedge clk);
      sa = dsp_a; sb = dsp_b; sop = dsp_opmode;
      @(posedge clk);
      #1;
      case (op_r)
         8'h01:   p = m;
         8'h09:   p = p + m;
         default: p = p;
      endcase
      m     = 48'(longint'($signed(a1)) * longint'($signed(b1)));
      a1    = sa;
      b1    = sb;
      op_r  = sop;
      dsp_p = p;
   end

   // Filter model: tracks phase by cycles since acceptance, not by the RTL's states
   logic [17:0] cm [N_TAPS];
   logic [17:0] xm [N_TAPS];
   logic [47:0] pend = '0, m_out = '0;
   int          phase = PH_IDLE, t = 0;
   bit          m_init = 0, m_rst = 0;

   function automatic logic [47:0] dot();
      longint s = 0;
      for (int k = 0; k < N_TAPS; k++)
         s += longint'($signed(cm[k])) * longint'($signed(xm[k]));
      return s[47:0];
   endfunction

   initial forever begin
      @(posedge clk);
      if (!rstn) begin
         m_init = 1; m_rst = 1; phase = PH_IDLE; t = 0; m_out = '0;
         for (int k = 0; k < N_TAPS; k++) begin cm[k] = '0; xm[k] = '0; end
      end else begin
         m_rst = 0;
         case (phase)
            PH_IDLE: begin
               if (coef_we && int'(coef_addr) < N_TAPS) cm[coef_addr] = coef_wdata;
               if (in_valid) begin
                  for (int k = N_TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
                  xm[0] = in_data;
                  pend  = dot();
                  t     = 0;
                  phase = PH_RUN;
               end
            end
            PH_RUN: begin
               t++;
               if (t == N_TAPS + DSP_LAT) begin phase = PH_OUT; m_out = pend; end
            end
            default: if (out_ready) phase = PH_IDLE;
         endcase
      end
   end

   // Per-cycle compare against the model, and collection of handed-off results
   logic [47:0] got [$];
   initial forever begin
      logic [17:0] ea, eb;
      logic [7:0]  eop;
      @(negedge clk);
      #1;
      if (m_init) begin
         ea = '0; eb = '0;
         if (phase == PH_RUN && t < N_TAPS) begin ea = cm[t]; eb = xm[t]; end
         if (m_rst) eop = 8'h00;
         else if (phase == PH_RUN && t >= OP_SKEW && t < N_TAPS + OP_SKEW)
            eop = (t == OP_SKEW) ? 8'h01 : 8'h09;
         else eop = 8'h08;
         chk("in_ready", 48'(in_ready), 48'(phase == PH_IDLE));
         chk("busy", 48'(busy), 48'(phase != PH_IDLE));
         chk("out_valid", 48'(out_valid), 48'(phase == PH_OUT));
         chk("out_data", out_data, m_out);
         chk("dsp_a", 48'(dsp_a), 48'(ea));
         chk("dsp_b", 48'(dsp_b), 48'(eb));
         chk("dsp_opmode", 48'(dsp_opmode), 48'(eop));
         if (out_valid && out_ready) got.push_back(out_data);
      end
   end

   task automatic send(input int d);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = 18'(d);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("send_timeout", 48'(in_ready), 48'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wr_coef(input int a, input int v);
      @(negedge clk);
      coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = 18'(v);
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int k = 0;
      while (got.size() < n && k < 200) begin @(negedge clk); k++; end
      chk("wait_out", 48'(got.size()), 48'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0]  ops [16];
      logic [17:0] av  [16];
      int lat, k;

      // reset held two cycles
      repeat (2) @(negedge clk);
      chk("rst_opmode", 48'(dsp_opmode), 48'h00);
      chk("rst_out_valid", 48'(out_valid), 48'd0);
      chk("rst_in_ready", 48'(in_ready), 48'd1);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_opmode", 48'(dsp_opmode), 48'h08);

      // impulse train with c = {1,2,3,4}
      for (int i = 0; i < N_TAPS; i++) wr_coef(i, i + 1);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) send(i);
      wait_out(4);
      chk("train0", got[0], 48'd1);
      chk("train1", got[1], 48'd4);
      chk("train2", got[2], 48'd10);
      chk("train3", got[3], 48'd20);

      // latency and opmode alignment for one sample: x = {5,4,3,2}
      send(5);
      lat = 1;
      ops[1] = dsp_opmode; av[1] = dsp_a;
      while (!out_valid && lat < 15) begin
         @(negedge clk); lat++;
         ops[lat] = dsp_opmode; av[lat] = dsp_a;
      end
      chk("latency", 48'(lat), 48'd8);
      chk("tap0_a", 48'(av[1]), 48'd1);
      chk("tap3_a", 48'(av[4]), 48'd4);
      chk("drain_a", 48'(av[5]), 48'd0);
      chk("op_before", 48'(ops[1]), 48'h08);
      chk("op_tap0", 48'(ops[2]), 48'h01);
      chk("op_tap1", 48'(ops[3]), 48'h09);
      chk("op_tap3", 48'(ops[5]), 48'h09);
      chk("op_after", 48'(ops[6]), 48'h08);
      wait_out(5);
      chk("single", got[4], 48'd30);

      // backpressure: x = {6,5,4,3} -> 40, then queued 7 -> 50
      out_ready = 1'b0;
      send(6);
      k = 0;
      while (!out_valid && k < 50) begin @(negedge clk); k++; end
      in_valid = 1'b1; in_data = 18'd7;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 48'(out_valid), 48'd1);
         chk("bp_data", out_data, 48'd40);
         chk("bp_in_ready", 48'(in_ready), 48'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      k = 0;
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      chk("bp_handshake_first", 48'(got.size()), 48'd6);
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(7);
      chk("bp0", got[5], 48'd40);
      chk("bp1", got[6], 48'd50);

      // coefficient write during ISSUE is dropped: x = {8,7,6,5}
      send(8);
      coef_we = 1'b1; coef_addr = '0; coef_wdata = 18'd7;
      @(negedge clk);
      coef_we = 1'b0;
      wait_out(8);
      chk("busy_write", got[7], 48'd60);
      // same write in IDLE lands: c = {7,2,3,4}, x = {9,8,7,6}
      wr_coef(0, 7);
      send(9);
      wait_out(9);
      chk("idle_write", got[8], 48'd124);

      // reset at tap 2 of a sample
      send(10);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_no_valid", 48'(out_valid), 48'd0);
      end
      chk("abort_count", 48'(got.size()), 48'd9);
      send(11);
      wait_out(10);
      chk("after_reset", got[9], 48'd0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
